// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t    : controller states (IDLE, CALC, FIX)
//   cnt_width  : width of the iteration counter for a given operand width
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // The counter counts down from width-1, so $clog2(width) bits are enough.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational.
// Ports:
//   rem_in   in  WIDTH  partial remainder before this step
//   quo_in   in  WIDTH  quotient register; its MSB is the next dividend bit
//   divisor  in  WIDTH  divisor magnitude
//   rem_out  out WIDTH  partial remainder after this step
//   quo_out  out WIDTH  quotient register shifted left, new bit in the LSB
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The shifted remainder can need WIDTH+1 bits; the extra bit of the
    // difference then acts as the borrow that decides restore vs keep.
    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        if (diff[WIDTH]) begin
            rem_out = shifted[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end else begin
            rem_out = diff[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring integer divider, one quotient bit per clock.
// Ports:
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous active-high reset
//   start        in   1      request, only sampled while idle
//   dividend     in   WIDTH  latched on an accepted start
//   divisor      in   WIDTH  latched on an accepted start
//   busy         out  1      division in progress
//   done         out  1      one-cycle pulse, results valid
//   quotient     out  WIDTH  held until the next done
//   remainder    out  WIDTH  held until the next done
//   div_by_zero  out  1      divisor was zero, held with the results
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state, next_state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem_p, quo_p, dvs_mag;
    logic [WIDTH-1:0] rem_nx, quo_nx;
    logic             neg_q, neg_r, dvs_zero;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    // The most negative value maps onto itself, which read as unsigned is
    // exactly its magnitude, so no extra bit is needed.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return (SIGNED && v[WIDTH-1]) ? negate(v) : v;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_p),
        .quo_in  (quo_p),
        .divisor (dvs_mag),
        .rem_out (rem_nx),
        .quo_out (quo_nx)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CALC;
            CALC:    if (count == '0) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Control and visible outputs: cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
            done  <= (state == FIX);
            if (state == IDLE && start) begin
                count <= CW'(WIDTH - 1);
            end else if (state == CALC) begin
                count <= count - CW'(1);
            end
            // A zero divisor makes every trial subtract succeed, so the
            // remainder path already reproduces the dividend; only the
            // quotient needs forcing because the sign fix would alter it.
            if (state == FIX) begin
                quotient    <= dvs_zero ? '1 : (neg_q ? negate(quo_p) : quo_p);
                remainder   <= neg_r ? negate(rem_p) : rem_p;
                div_by_zero <= dvs_zero;
            end
        end
    end

    // Datapath registers: no reset needed, always loaded before use.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            rem_p    <= '0;
            quo_p    <= magnitude(dividend);
            dvs_mag  <= magnitude(divisor);
            neg_r    <= SIGNED && dividend[WIDTH-1];
            neg_q    <= SIGNED && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            dvs_zero <= (divisor == '0);
        end else if (state == CALC) begin
            rem_p <= rem_nx;
            quo_p <= quo_nx;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: four instances (WIDTH 4/16, unsigned/signed),
// expected results pushed at issue time, popped and compared on done.
module tb_seq_divider;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]  start, busy, done, dbz;
    logic [15:0] dvd [4];
    logic [15:0] dvs [4];
    logic [3:0]  q0, r0, q1, r1;
    logic [15:0] q2, r2, q3, r3;
    logic [15:0] quo_w [4];
    logic [15:0] rem_w [4];

    assign quo_w[0] = {12'd0, q0};
    assign rem_w[0] = {12'd0, r0};
    assign quo_w[1] = {12'd0, q1};
    assign rem_w[1] = {12'd0, r1};
    assign quo_w[2] = q2;
    assign rem_w[2] = r2;
    assign quo_w[3] = q3;
    assign rem_w[3] = r3;

    seq_divider #(.WIDTH(4), .SIGNED(0)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .dividend(dvd[0][3:0]), .divisor(dvs[0][3:0]),
        .busy(busy[0]), .done(done[0]), .quotient(q0), .remainder(r0), .div_by_zero(dbz[0]));
    seq_divider #(.WIDTH(4), .SIGNED(1)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .dividend(dvd[1][3:0]), .divisor(dvs[1][3:0]),
        .busy(busy[1]), .done(done[1]), .quotient(q1), .remainder(r1), .div_by_zero(dbz[1]));
    seq_divider #(.WIDTH(16), .SIGNED(0)) u2 (
        .clk(clk), .rst(rst), .start(start[2]), .dividend(dvd[2]), .divisor(dvs[2]),
        .busy(busy[2]), .done(done[2]), .quotient(q2), .remainder(r2), .div_by_zero(dbz[2]));
    seq_divider #(.WIDTH(16), .SIGNED(1)) u3 (
        .clk(clk), .rst(rst), .start(start[3]), .dividend(dvd[3]), .divisor(dvs[3]),
        .busy(busy[3]), .done(done[3]), .quotient(q3), .remainder(r3), .div_by_zero(dbz[3]));

    typedef struct {
        int          id;
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
        longint      due;
    } exp_t;

    exp_t   sbq[$];
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int w_of(input int id);
        return (id < 2) ? 4 : 16;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input int id, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [15:0] r, output logic z);
        longint one  = 1;
        int     w    = w_of(id);
        longint mask = (one << w) - 1;
        longint ua   = longint'(a) & mask;
        longint ub   = longint'(b) & mask;
        longint sa, sb, sq, sr;
        if (ub == 0) begin
            q = 16'(mask);
            r = 16'(ua);
            z = 1'b1;
        end else begin
            z = 1'b0;
            if (id % 2 == 0) begin
                q = 16'(ua / ub);
                r = 16'(ua % ub);
            end else begin
                sa = (ua >= (one << (w - 1))) ? ua - (one << w) : ua;
                sb = (ub >= (one << (w - 1))) ? ub - (one << w) : ub;
                if (sa == -(one << (w - 1)) && sb == -1) begin
                    sq = sa;
                    sr = 0;
                end else begin
                    sq = sa / sb;   // truncates toward zero
                    sr = sa % sb;   // sign follows the dividend
                end
                q = 16'(sq & mask);
                r = 16'(sr & mask);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (done[i] === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done inst=%0d actual=1 expected=0", i);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("done_instance", i, e.id);
                    chk("quotient", quo_w[i], e.q);
                    chk("remainder", rem_w[i], e.r);
                    chk("div_by_zero", dbz[i], e.z);
                    chk("latency_cycle", cyc, e.due);
                    chk("busy_at_done", busy[i], 0);
                end
            end
        end
    end

    // Drive start for one edge; call before the edge (e.g. just after a negedge).
    task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b,
                         input bit accepted);
        exp_t e;
        dvd[id]   = a;
        dvs[id]   = b;
        start[id] = 1'b1;
        @(posedge clk);
        #1;
        start[id] = 1'b0;
        if (accepted) begin
            e.id = id;
            model(id, a, b, e.q, e.r, e.z);
            e.due = cyc + w_of(id) + 1;
            sbq.push_back(e);
        end
    endtask

    // Returns at the negedge where done is seen, so a follow-up issue is back-to-back.
    task automatic wait_done(input int id);
        bit seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (done[id] === 1'b1) seen = 1;
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    initial begin
        logic [15:0] a, b;
        rst   = 1'b1;
        start = '0;
        for (int i = 0; i < 4; i++) begin
            dvd[i] = '0;
            dvs[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("reset_busy", busy[i], 0);
            chk("reset_done", done[i], 0);
            chk("reset_quotient", quo_w[i], 0);
            chk("reset_remainder", rem_w[i], 0);
            chk("reset_dbz", dbz[i], 0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed 4-bit unsigned: 7/2, back-to-back 6/2, divide by zero.
        issue(0, 16'h7, 16'h2, 1);
        wait_done(0);
        issue(0, 16'h6, 16'h2, 1);
        wait_done(0);
        @(negedge clk);
        issue(0, 16'hA, 16'h0, 1);
        wait_done(0);
        @(negedge clk);

        // Directed 4-bit signed: -7/2, -8/-1, divide by zero with negative dividend.
        issue(1, 16'h9, 16'h2, 1);
        wait_done(1);
        issue(1, 16'h8, 16'hF, 1);
        wait_done(1);
        issue(1, 16'hA, 16'h0, 1);
        wait_done(1);
        @(negedge clk);

        // Start while busy is ignored.
        issue(0, 16'h7, 16'h2, 1);
        @(negedge clk);
        issue(0, 16'hF, 16'h1, 0);
        wait_done(0);
        repeat (8) @(negedge clk);

        // Reset mid-division clears outputs at once and discards the result.
        issue(0, 16'hE, 16'h3, 1);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midreset_busy", busy[0], 0);
        chk("midreset_done", done[0], 0);
        chk("midreset_quotient", quo_w[0], 0);
        chk("midreset_remainder", rem_w[0], 0);
        chk("midreset_dbz", dbz[0], 0);
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        issue(0, 16'h9, 16'h4, 1);
        wait_done(0);

        // Exhaustive 4-bit, both modes.
        for (int id = 0; id < 2; id++) begin
            for (int x = 0; x < 256; x++) begin
                issue(id, 16'(x & 15), 16'(x >> 4), 1);
                wait_done(id);
            end
        end

        // Random 16-bit sweep, both modes, with forced corner operands.
        for (int n = 0; n < 150; n++) begin
            for (int id = 2; id < 4; id++) begin
                a = 16'($urandom);
                case ($urandom_range(0, 7))
                    0:       b = 16'h0000;
                    1:       begin a = 16'h8000; b = 16'hFFFF; end
                    2:       b = 16'($urandom_range(1, 15));
                    3:       b = 16'h0001;
                    default: b = 16'($urandom);
                endcase
                issue(id, a, b, 1);
                wait_done(id);
                if ($urandom_range(0, 1) == 1) @(negedge clk);
            end
        end

        repeat (20) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
